// File: rtl/i2c_apb_regs.sv
// ---------------------------------------------------------------------------
// i2c_apb_regs
// APB slave register bank in front of the I2C byte engine. Holds the control,
// prescale and target-address registers plus an 8-bit TX FIFO (APB -> core)
// and an 8-bit RX FIFO (core -> APB). Every APB transfer takes exactly one
// wait state: IDLE -> WAIT -> DONE, with pready/prdata/pslverr registered.
//
// Ports
//   pclk, preset          : clock, synchronous active-high reset
//   psel .. pwdata        : APB request (paddr[7:2] decoded)
//   prdata/pready/pslverr : APB response, valid for the single DONE cycle
//   core_en, core_ack_en  : CTRL.EN / CTRL.ACK
//   cmd_start, cmd_stop   : one-cycle command pulses after a CTRL write
//   prescale, slv_addr    : SCL divider and 7-bit target address
//   tx_data/tx_valid/tx_ready : TX FIFO head toward the core
//   rx_data/rx_valid      : byte strobe from the core into the RX FIFO
//   core_busy             : transfer-in-progress status from the core
//   irq                   : interrupt (only with I2C_APB_IRQ_EN defined)
//
// Build option: define I2C_APB_IRQ_EN to add the irq output and the IRQ_EN
// register at offset 0x18.
// ---------------------------------------------------------------------------
module i2c_apb_regs #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd99
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        core_en,
    output logic        core_ack_en,
    output logic        cmd_start,
    output logic        cmd_stop,
    output logic [15:0] prescale,
    output logic [6:0]  slv_addr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
`ifdef I2C_APB_IRQ_EN
    output logic        irq,
`endif
    input  logic        core_busy
);

    localparam int         AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // Word offsets (paddr[7:2])
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h01;
    localparam logic [5:0] A_PRESC  = 6'h02;
    localparam logic [5:0] A_TX     = 6'h03;
    localparam logic [5:0] A_RX     = 6'h04;
    localparam logic [5:0] A_SLV    = 6'h05;
`ifdef I2C_APB_IRQ_EN
    localparam logic [5:0] A_IRQ    = 6'h06;
`endif

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

    state_t        r_state;
    logic [5:0]    r_addr;
    logic          r_write;
    logic [15:0]   r_wdata;
    logic [31:0]   r_prdata;
    logic          r_pready;
    logic          r_pslverr;
    logic          r_en;
    logic          r_ack;
    logic          r_cmd_start;
    logic          r_cmd_stop;
    logic [15:0]   r_prescale;
    logic [6:0]    r_slv_addr;
    logic          r_rx_ovf;
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [AW:0]   r_tx_cnt, r_rx_cnt;

    logic [31:0]   w_rdata;
    logic          w_err;
    logic          w_wr_en;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_ovf_set;
    logic [5:0]    w_status;
    logic          w_unused;

    assign w_unused   = ^{paddr[31:8], paddr[1:0], pwdata[31:16]};

    assign w_tx_full  = (r_tx_cnt == DEPTH_C);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == DEPTH_C);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_status   = {r_rx_ovf, core_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    // Side effects commit only in DONE, and only for accesses that did not error
    assign w_wr_en      = (r_state == ST_DONE) & r_write & ~r_pslverr;
    assign w_rx_pop     = (r_state == ST_DONE) & ~r_write & ~r_pslverr & (r_addr == A_RX);
    assign w_tx_pop     = ~w_tx_empty & tx_ready;
    assign w_tx_push    = w_wr_en & (r_addr == A_TX) & (~w_tx_full | w_tx_pop);
    // A full RX FIFO still accepts a byte when the APB pop lands in the same cycle
    assign w_rx_push    = rx_valid & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf_set = rx_valid & w_rx_full & ~w_rx_pop;

    assign prdata      = r_prdata;
    assign pready      = r_pready;
    assign pslverr     = r_pslverr;
    assign core_en     = r_en;
    assign core_ack_en = r_ack;
    assign cmd_start   = r_cmd_start;
    assign cmd_stop    = r_cmd_stop;
    assign prescale    = r_prescale;
    assign slv_addr    = r_slv_addr;
    assign tx_valid    = ~w_tx_empty;
    assign tx_data     = r_tx_mem[r_tx_rptr];

`ifdef I2C_APB_IRQ_EN
    logic [2:0] r_irq_en;
    logic       r_irq;
    assign irq = r_irq;
`endif

    // Read data / error decode for the latched access, sampled at WAIT->DONE
    always_comb begin
        w_rdata = 32'd0;
        w_err   = 1'b0;
        case (r_addr)
            A_CTRL:   w_rdata = {30'd0, r_ack, r_en};
            A_STATUS: w_rdata = {26'd0, w_status};
            A_PRESC:  w_rdata = {16'd0, r_prescale};
            A_TX:     w_err   = r_write ? w_tx_full : 1'b1;
            A_RX: begin
                if (r_write) begin
                    w_err = 1'b1;
                end else if (w_rx_empty) begin
                    w_err = 1'b1;
                end else begin
                    w_rdata = {24'd0, r_rx_mem[r_rx_rptr]};
                end
            end
            A_SLV:    w_rdata = {25'd0, r_slv_addr};
`ifdef I2C_APB_IRQ_EN
            A_IRQ:    w_rdata = {29'd0, r_irq_en};
`endif
            default:  w_err   = 1'b1;
        endcase
    end

    // APB handshake FSM with registered response
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_addr    <= 6'd0;
            r_write   <= 1'b0;
            r_wdata   <= 16'd0;
            r_prdata  <= 32'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= 32'd0;
                    if (psel && !penable) begin
                        r_state <= ST_WAIT;
                        r_addr  <= paddr[7:2];
                        r_write <= pwrite;
                        r_wdata <= pwdata[15:0];
                    end
                end
                ST_WAIT: begin
                    // Master abandoned the transfer: drop it without side effects
                    if (!psel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state   <= ST_DONE;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= r_write ? 32'd0 : w_rdata;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= 32'd0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Control/config registers, command pulses and sticky overflow flag
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_en        <= 1'b0;
            r_ack       <= 1'b0;
            r_cmd_start <= 1'b0;
            r_cmd_stop  <= 1'b0;
            r_prescale  <= PRESCALE_RST;
            r_slv_addr  <= 7'd0;
            r_rx_ovf    <= 1'b0;
        end else begin
            r_cmd_start <= w_wr_en & (r_addr == A_CTRL) & r_wdata[2];
            r_cmd_stop  <= w_wr_en & (r_addr == A_CTRL) & r_wdata[3];
            if (w_wr_en) begin
                case (r_addr)
                    A_CTRL: begin
                        r_en  <= r_wdata[0];
                        r_ack <= r_wdata[1];
                    end
                    A_PRESC: r_prescale <= r_wdata;
                    A_SLV:   r_slv_addr <= r_wdata[6:0];
                    default: r_prescale <= r_prescale;
                endcase
            end
            // A new overflow beats a simultaneous W1C
            if (w_rx_ovf_set) begin
                r_rx_ovf <= 1'b1;
            end else if (w_wr_en && (r_addr == A_STATUS) && r_wdata[5]) begin
                r_rx_ovf <= 1'b0;
            end
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1'b1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1'b1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + (AW+1)'(1'b1);
                2'b01:   r_tx_cnt <= r_tx_cnt - (AW+1)'(1'b1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1'b1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1'b1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + (AW+1)'(1'b1);
                2'b01:   r_rx_cnt <= r_rx_cnt - (AW+1)'(1'b1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // FIFO storage (contents need no reset; occupancy gates visibility)
    always_ff @(posedge pclk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= r_wdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
    end

`ifdef I2C_APB_IRQ_EN
    // Interrupt enable register and registered interrupt output
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_irq_en <= 3'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_en && (r_addr == A_IRQ)) r_irq_en <= r_wdata[2:0];
            r_irq <= (r_irq_en[0] & w_tx_empty) | (r_irq_en[1] & ~w_rx_empty) |
                     (r_irq_en[2] & r_rx_ovf);
        end
    end
`endif

endmodule

// File: doc/i2c_apb_regs.md
Name: i2c_apb_regs

Overview:
- APB slave register bank for the I2C controller.
- Consumes transactions driven on the team's APB interface (psel/penable/pwrite/paddr/pwdata -> prdata/pready/pslverr).
- Exposes control/prescale/address registers, an 8-bit TX FIFO and an 8-bit RX FIFO to the downstream I2C byte engine.
- Sits between the APB bus and the I2C core.

Parameters:
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, 2..64.
- PRESCALE_RST, 16'd99, reset value of the PRESCALE register.

Ports:
- pclk  input  1  APB clock; all logic on posedge.
- preset  input  1  synchronous reset, active-high.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address; only [7:0] decoded, [1:0] ignored.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid while pready=1.
- pready  output  1  transfer complete.
- pslverr  output  1  error, valid while pready=1.
- core_en  output  1  CTRL.EN.
- core_ack_en  output  1  CTRL.ACK: master ACKs received bytes.
- cmd_start  output  1  one-cycle START request pulse.
- cmd_stop  output  1  one-cycle STOP request pulse.
- prescale  output  16  SCL divider.
- slv_addr  output  7  target address.
- tx_data  output  8  TX FIFO head.
- tx_valid  output  1  TX FIFO not empty.
- tx_ready  input  1  core pops TX head when tx_valid & tx_ready.
- rx_data  input  8  byte from core.
- rx_valid  input  1  core pushes rx_data (single-cycle strobe).
- core_busy  input  1  I2C transfer in progress.

Behaviour:
- Reset, synchronous while preset=1: prdata=0, pready=0, pslverr=0, core_en=0, core_ack_en=0, cmd_start=0, cmd_stop=0, prescale=PRESCALE_RST, slv_addr=0, both FIFOs empty, tx_valid=0, rx_ovf=0, FSM=IDLE.
- Reset mid-transfer aborts the transfer; the master must restart it.
- APB FSM:
  - IDLE: psel & !penable (setup) -> WAIT.
  - WAIT: pready=0, one mandatory wait state -> DONE.
  - DONE: pready=1 for exactly one cycle, with prdata and pslverr registered -> IDLE.
  - Each transfer therefore completes 2 cycles after the setup cycle.
  - If psel drops in WAIT (protocol violation) -> IDLE, no side effects.
- Side effects (register write, FIFO push/pop, W1C) commit on the DONE cycle only; the read value is sampled at the WAIT->DONE edge.
- Register map, offset = paddr[7:0]:
  - 0x00 CTRL RW: [0] EN, [1] ACK. [2] START and [3] STOP are write-1-pulse, read 0; writing 1 produces a 1-cycle cmd_start/cmd_stop in the cycle after DONE.
  - 0x04 STATUS RO: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] core_busy, [5] rx_ovf. A write of 1 to [5] clears rx_ovf (W1C); no pslverr for this write.
  - 0x08 PRESCALE RW [15:0].
  - 0x0C TXDATA WO: push pwdata[7:0]. Push when full: pslverr=1, data dropped. Read: prdata=0, pslverr=1.
  - 0x10 RXDATA RO: pop, prdata={24'b0, head}. Pop when empty: prdata=0, pslverr=1. Write: pslverr=1, ignored.
  - 0x14 SLVADDR RW [6:0].
  - Any other offset: pslverr=1, prdata=0, no effect.
- Unused register bits read 0.
- FIFOs:
  - Occupancy counter 0..FIFO_DEPTH with wrapping read/write pointers.
  - Simultaneous push and pop on a full or empty FIFO: both succeed when legal (pop of empty is illegal, push of full succeeds only if the pop occurs in the same cycle); count unchanged.
  - RX push while full and no concurrent pop: byte dropped, rx_ovf set (sticky).
  - Concurrent rx_ovf set and W1C clear: set wins.
  - tx_data is combinational from the head entry.

Optional Feature:
- Macro I2C_APB_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0, registered).
  - Adds register 0x18 IRQ_EN RW [2:0].
  - irq = (IRQ_EN[0] & tx_empty) | (IRQ_EN[1] & !rx_empty) | (IRQ_EN[2] & rx_ovf), asserting 1 cycle after its cause.
- Not defined:
  - No irq port.
  - 0x18 decodes as an invalid offset (pslverr=1).

Test Plan:
- Reset, then read PRESCALE (0x08) -> pready high exactly 2 cycles after setup, prdata=0x63, pslverr=0.
- Write CTRL=0x5 (EN|START) -> core_en=1; cmd_start high 1 cycle; CTRL readback=0x1.
- Push 8 bytes 0x10..0x17 to TXDATA with tx_ready=0, then a 9th -> 9th gets pslverr=1, STATUS[0]=1; raise tx_ready -> tx_data sequence 0x10..0x17, then tx_valid=0.
- Read RXDATA when empty -> prdata=0, pslverr=1. Pulse rx_valid 9 times (0xA0..0xA8) -> STATUS[5]=1; 8 reads return 0xA0..0xA7; write STATUS=0x20 -> rx_ovf=0.
- Access offset 0x40 (read and write) -> pslverr=1, prdata=0, no register changes.
- Assert preset between setup and DONE of a TXDATA write -> no push, pready=0, all outputs at reset values.
